// File: rtl/lane_tx_scheduler.sv
// Round-robin scheduler sharing one byte-wide transmit path among four byte lanes.
// Latency: byte sampled at its transfer edge is on data_out right after that edge (1 clk).
// Backpressure: ready_i is high only for the granted lane while ACTIVE; other lanes wait.
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   valid0..3 / data_in0..3     per-lane byte offer
//   ready0..3                   per-lane consume strobe (byte taken when valid_i & ready_i)
//   data_out/valid_out/lane_out registered byte stream tagged with source lane
//   idle_out                    data_out carries IDLE_SYM
// Optional (macro SCHED_STATS_EN): cnt0..cnt3 saturating per-lane transfer counters,
//   collision = number of non-granted lanes holding valid at each transfer edge.
module lane_tx_scheduler #(
   parameter int          BURST    = 1,
   parameter logic [7:0]  IDLE_SYM = 8'hBC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid0,
   input  logic        valid1,
   input  logic        valid2,
   input  logic        valid3,
   input  logic [7:0]  data_in0,
   input  logic [7:0]  data_in1,
   input  logic [7:0]  data_in2,
   input  logic [7:0]  data_in3,
   output logic        ready0,
   output logic        ready1,
   output logic        ready2,
   output logic        ready3,
   output logic [7:0]  data_out,
   output logic        valid_out,
   output logic [1:0]  lane_out,
   output logic        idle_out
`ifdef SCHED_STATS_EN
   ,
   output logic [15:0] cnt0,
   output logic [15:0] cnt1,
   output logic [15:0] cnt2,
   output logic [15:0] cnt3,
   output logic [1:0]  collision
`endif
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t     state;
   logic [1:0] gnt;
   logic [1:0] last;
   logic [3:0] burst_cnt;

   logic [3:0] vld;
   logic [7:0] din [4];
   logic       xfer;
   logic       burst_done;
   logic [2:0] srch_last;   // {hit, lane} searching from last+1
   logic [2:0] srch_gnt;    // {hit, lane} searching from gnt+1 (last after this transfer)

   assign vld    = {valid3, valid2, valid1, valid0};
   assign din[0] = data_in0;
   assign din[1] = data_in1;
   assign din[2] = data_in2;
   assign din[3] = data_in3;

   // First valid lane in the order from+1, from+2, from+3, from. Scanning downward
   // lets the nearest candidate overwrite farther ones.
   function automatic logic [2:0] rr_search(input logic [1:0] from, input logic [3:0] v);
      logic [2:0] r;
      logic [1:0] l;
      r = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         l = from + 2'(k);
         if (v[l]) r = {1'b1, l};
      end
      return r;
   endfunction

   assign srch_last  = rr_search(last, vld);
   assign srch_gnt   = rr_search(gnt, vld);
   assign xfer       = (state == ACTIVE) && vld[gnt];
   assign burst_done = (burst_cnt == 4'(BURST - 1));

   assign ready0 = (state == ACTIVE) && (gnt == 2'd0);
   assign ready1 = (state == ACTIVE) && (gnt == 2'd1);
   assign ready2 = (state == ACTIVE) && (gnt == 2'd2);
   assign ready3 = (state == ACTIVE) && (gnt == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         gnt       <= 2'd0;
         last      <= 2'd3;
         burst_cnt <= 4'd0;
         data_out  <= IDLE_SYM;
         valid_out <= 1'b0;
         lane_out  <= 2'd0;
         idle_out  <= 1'b1;
      end else begin
         if (xfer) begin
            data_out  <= din[gnt];
            valid_out <= 1'b1;
            lane_out  <= gnt;
            idle_out  <= 1'b0;
         end else begin
            data_out  <= IDLE_SYM;
            valid_out <= 1'b0;
            idle_out  <= 1'b1;
         end

         if (xfer) begin
            last <= gnt;
            if (burst_done) begin
               burst_cnt <= 4'd0;
               if (srch_gnt[2]) gnt   <= srch_gnt[1:0];
               else             state <= IDLE;
            end else begin
               burst_cnt <= burst_cnt + 4'd1;
            end
         end else begin
            // Idle with requests, or granted lane ran dry: both re-search from last.
            burst_cnt <= 4'd0;
            if (srch_last[2]) begin
               gnt   <= srch_last[1:0];
               state <= ACTIVE;
            end else begin
               state <= IDLE;
            end
         end
      end
   end

`ifdef SCHED_STATS_EN
   logic [15:0] cnt [4];
   logic [3:0]  others;

   assign others = vld & ~(4'b0001 << gnt);
   assign cnt0 = cnt[0];
   assign cnt1 = cnt[1];
   assign cnt2 = cnt[2];
   assign cnt3 = cnt[3];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) cnt[i] <= 16'd0;
         collision <= 2'd0;
      end else if (xfer) begin
         if (cnt[gnt] != 16'hFFFF) cnt[gnt] <= cnt[gnt] + 16'd1;
         collision <= 2'(others[0]) + 2'(others[1]) + 2'(others[2]) + 2'(others[3]);
      end
   end
`endif

endmodule
